// File: rtl/trace_capture_unit_pkg.sv
// Shared definitions for the retire-trace capture unit: FSM state encoding,
// trigger mode codes and trace entry layout helpers.
package trace_capture_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_POST  = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [1:0] TRIG_PC     = 2'b00;
    localparam logic [1:0] TRIG_STORE  = 2'b01;
    localparam logic [1:0] TRIG_BRANCH = 2'b10;
    localparam logic [1:0] TRIG_MANUAL = 2'b11;

    localparam int INSTR_W = 32;
    localparam int RD_W    = 5;

    // Entry layout, MSB first: {pc, instr, rd, wdata, reg_write, mem_write}
    function automatic int entry_width(input int xlen);
        return 2 * xlen + INSTR_W + RD_W + 2;
    endfunction

endpackage

// File: rtl/trace_capture_unit_if.sv
// Retire/trigger/readout bundle between a core (or bench) and the trace unit.
// The master side drives retire information and trace control; the slave side
// is the trace unit, which returns status and readout data.
interface trace_capture_unit_if #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 16
) ();
    import trace_capture_unit_pkg::*;

    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRY_W = entry_width(XLEN);

    // Retire information
    logic                retire_valid;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     pc_next;
    logic [INSTR_W-1:0]  instr;
    logic [RD_W-1:0]     rd;
    logic [XLEN-1:0]     wdata;
    logic                reg_write;
    logic                mem_write;
    logic [XLEN-1:0]     alu_result;
    logic                branch_taken;

    // Trace control
    logic                arm;
    logic [1:0]          trig_mode;
    logic [XLEN-1:0]     trig_value;
    logic                trig_force;
    logic [AW-1:0]       rd_addr;

    // Status and readout
    logic [1:0]          state;
    logic [ENTRY_W-1:0]  rd_data;
    logic [AW:0]         entries;
    logic [AW-1:0]       trig_pos;
    logic                halt;
    logic [31:0]         retire_count;

    modport master (
        output retire_valid, pc, pc_next, instr, rd, wdata, reg_write, mem_write,
               alu_result, branch_taken, arm, trig_mode, trig_value, trig_force, rd_addr,
        input  state, rd_data, entries, trig_pos, halt, retire_count
    );

    modport slave (
        input  retire_valid, pc, pc_next, instr, rd, wdata, reg_write, mem_write,
               alu_result, branch_taken, arm, trig_mode, trig_value, trig_force, rd_addr,
        output state, rd_data, entries, trig_pos, halt, retire_count
    );

endinterface

// File: rtl/trace_capture_unit_ram.sv
// Trace storage: DEPTH x WIDTH, synchronous write, asynchronous read, no reset.
module trace_capture_unit_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 167,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Store one trace entry per enabled cycle
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/trace_capture_unit.sv
// Retire-trace and halt monitor. Captures retired instructions into a circular
// buffer while armed, freezes POST_TRIG entries after a trigger, and flags a
// halted program once the PC has looped on itself HALT_CYCLES retires in a row.
module trace_capture_unit
    import trace_capture_unit_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int DEPTH       = 16,
    parameter int POST_TRIG   = 8,
    parameter int HALT_CYCLES = 16
) (
    input logic                 clk,
    input logic                 reset,
    trace_capture_unit_if.slave bus
);

    localparam int AW      = $clog2(DEPTH);
    localparam int EW      = entry_width(XLEN);
    localparam int LCW     = $clog2(HALT_CYCLES + 1);
    localparam int PCW     = AW + 1;

    localparam logic [AW:0]    ENT_FULL  = (AW + 1)'(DEPTH);
    localparam logic [LCW-1:0] LOOP_MAX  = LCW'(HALT_CYCLES);
    localparam logic [PCW-1:0] POST_LAST = PCW'(POST_TRIG - 1);

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]     entries_q, entries_d;
    logic [PCW-1:0]  post_cnt_q, post_cnt_d;
    logic [AW-1:0]   trig_ptr_q, trig_ptr_d;
    logic [LCW-1:0]  loop_cnt_q, loop_cnt_d;
    logic            halt_q, halt_d;
    logic [31:0]     retire_count_q, retire_count_d;

    logic            trig_hit;
    logic            do_write;
    logic [EW-1:0]   wr_entry;
    logic [AW-1:0]   oldest;
    logic [AW-1:0]   rd_idx;
    logic [EW-1:0]   ram_rdata;

    assign wr_entry = {bus.pc, bus.instr, bus.rd, bus.wdata, bus.reg_write, bus.mem_write};

    trace_capture_unit_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clk     (clk),
        .we_i    (do_write),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_idx),
        .rdata_o (ram_rdata)
    );

    // Trigger comparator for the selected mode
    always_comb begin
        trig_hit = 1'b0;
        case (bus.trig_mode)
            TRIG_PC:     trig_hit = (bus.pc == bus.trig_value);
            TRIG_STORE:  trig_hit = bus.mem_write && (bus.alu_result == bus.trig_value);
            TRIG_BRANCH: trig_hit = bus.branch_taken;
            TRIG_MANUAL: trig_hit = bus.trig_force;
            default:     trig_hit = 1'b0;
        endcase
    end

    // Next-state: FSM, write pointer, occupancy, post-trigger count, halt detector
    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        entries_d      = entries_q;
        post_cnt_d     = post_cnt_q;
        trig_ptr_d     = trig_ptr_q;
        loop_cnt_d     = loop_cnt_q;
        halt_d         = halt_q;
        retire_count_d = retire_count_q;
        do_write       = 1'b0;

        if (bus.arm) begin
            // arm wins over a coincident retire: nothing from that retire is kept
            state_d        = ST_ARMED;
            wr_ptr_d       = '0;
            entries_d      = '0;
            post_cnt_d     = '0;
            trig_ptr_d     = '0;
            loop_cnt_d     = '0;
            halt_d         = 1'b0;
            retire_count_d = '0;
        end else if (bus.retire_valid) begin
            if (retire_count_q != '1) begin
                retire_count_d = retire_count_q + 32'd1;
            end

            if (bus.pc_next == bus.pc) begin
                if (loop_cnt_q != LOOP_MAX) begin
                    loop_cnt_d = loop_cnt_q + 1'b1;
                end
            end else begin
                loop_cnt_d = '0;
            end
            if (loop_cnt_d == LOOP_MAX) begin
                halt_d = 1'b1;
            end

            if (state_q == ST_ARMED || state_q == ST_POST) begin
                do_write = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (entries_q != ENT_FULL) begin
                    entries_d = entries_q + 1'b1;
                end
            end

            case (state_q)
                ST_ARMED: begin
                    if (trig_hit) begin
                        trig_ptr_d = wr_ptr_q;
                        post_cnt_d = '0;
                        state_d    = (POST_TRIG == 0) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    post_cnt_d = post_cnt_q + 1'b1;
                    if (post_cnt_q == POST_LAST) begin
                        state_d = ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            wr_ptr_q       <= '0;
            entries_q      <= '0;
            post_cnt_q     <= '0;
            trig_ptr_q     <= '0;
            loop_cnt_q     <= '0;
            halt_q         <= 1'b0;
            retire_count_q <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            entries_q      <= entries_d;
            post_cnt_q     <= post_cnt_d;
            trig_ptr_q     <= trig_ptr_d;
            loop_cnt_q     <= loop_cnt_d;
            halt_q         <= halt_d;
            retire_count_q <= retire_count_d;
        end
    end

    // Readout indices are relative to the oldest valid entry; once the buffer
    // has wrapped the oldest entry sits at the write pointer.
    assign oldest = (entries_q == ENT_FULL) ? wr_ptr_q : '0;
    assign rd_idx = oldest + bus.rd_addr;

    assign bus.rd_data      = (state_q == ST_DONE && {1'b0, bus.rd_addr} < entries_q)
                              ? ram_rdata : '0;
    assign bus.trig_pos     = trig_ptr_q - oldest;
    assign bus.state        = state_q;
    assign bus.entries      = entries_q;
    assign bus.halt         = halt_q;
    assign bus.retire_count = retire_count_q;

endmodule

// File: tb/tb_trace_capture_unit.sv
// Directed bench for trace_capture_unit: trigger modes, wrap, halt detection,
// arm priority, asynchronous reset and the POST_TRIG=0 variant.
module tb_trace_capture_unit;

    localparam int XLEN  = 64;
    localparam int DEPTH = 16;
    localparam int EW    = 2 * XLEN + 39;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] SD  = 32'h02703023;
    localparam logic [31:0] BEQ = 32'h02208863;
    localparam logic [31:0] JAL = 32'h0000006f;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [EW-1:0] d;

    trace_capture_unit_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus1 ();
    trace_capture_unit_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus2 ();

    trace_capture_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(8), .HALT_CYCLES(16)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));
    trace_capture_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(0), .HALT_CYCLES(16)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2));

    always #5 clk = ~clk;

    function automatic logic [EW-1:0] ent(input logic [63:0] pc, input logic [31:0] ins,
                                          input logic [4:0] rdv, input logic [63:0] wd,
                                          input logic rw, input logic mw);
        return {pc, ins, rdv, wd, rw, mw};
    endfunction

    function automatic logic [EW-1:0] ent_s(input logic [63:0] pc);
        logic [63:0] p;
        p = pc;
        return ent(p, NOP, p[6:2], p * 3, 1'b1, 1'b0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] pc, input logic [63:0] pcn, input logic [31:0] ins,
                         input logic [4:0] rdv, input logic [63:0] wd, input logic rw,
                         input logic mw, input logic [63:0] alu, input logic br, input logic vld);
        bus1.pc = pc; bus1.pc_next = pcn; bus1.instr = ins; bus1.rd = rdv; bus1.wdata = wd;
        bus1.reg_write = rw; bus1.mem_write = mw; bus1.alu_result = alu;
        bus1.branch_taken = br; bus1.retire_valid = vld;
        bus2.pc = pc; bus2.pc_next = pcn; bus2.instr = ins; bus2.rd = rdv; bus2.wdata = wd;
        bus2.reg_write = rw; bus2.mem_write = mw; bus2.alu_result = alu;
        bus2.branch_taken = br; bus2.retire_valid = vld;
    endtask

    task automatic retire(input logic [63:0] pc, input logic [63:0] pcn, input logic [31:0] ins,
                          input logic [4:0] rdv, input logic [63:0] wd, input logic rw,
                          input logic mw, input logic [63:0] alu, input logic br);
        drive(pc, pcn, ins, rdv, wd, rw, mw, alu, br, 1'b1);
        tick();
        bus1.retire_valid = 1'b0;
        bus2.retire_valid = 1'b0;
    endtask

    task automatic straight(input logic [63:0] pc);
        logic [63:0] p;
        p = pc;
        retire(p, p + 64'd4, NOP, p[6:2], p * 3, 1'b1, 1'b0, p + 64'h100, 1'b0);
    endtask

    task automatic loop_retire();
        retire(64'h80, 64'h80, JAL, 5'd0, 64'd0, 1'b0, 1'b0, 64'h80, 1'b0);
    endtask

    task automatic set_mode(input logic [1:0] mode, input logic [63:0] val, input logic frc);
        bus1.trig_mode = mode; bus1.trig_value = val; bus1.trig_force = frc;
        bus2.trig_mode = mode; bus2.trig_value = val; bus2.trig_force = frc;
    endtask

    task automatic do_arm();
        bus1.arm = 1'b1; bus2.arm = 1'b1;
        tick();
        bus1.arm = 1'b0; bus2.arm = 1'b0;
    endtask

    task automatic read1(input logic [3:0] a, output logic [EW-1:0] q);
        bus1.rd_addr = a;
        #1;
        q = bus1.rd_data;
    endtask

    task automatic read2(input logic [3:0] a, output logic [EW-1:0] q);
        bus2.rd_addr = a;
        #1;
        q = bus2.rd_data;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive('0, '0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        set_mode(2'b00, '0, 1'b0);
        bus1.arm = 1'b0; bus2.arm = 1'b0;
        bus1.rd_addr = '0; bus2.rd_addr = '0;
        repeat (2) tick();
        checks++; if (bus1.state !== 2'b00) begin errors++; $display("FAIL reset_state: got %0h expected 0", bus1.state); end
        checks++; if (bus1.entries !== 5'd0) begin errors++; $display("FAIL reset_entries: got %0d expected 0", bus1.entries); end
        checks++; if (bus1.trig_pos !== 4'd0) begin errors++; $display("FAIL reset_trig_pos: got %0d expected 0", bus1.trig_pos); end
        checks++; if (bus1.halt !== 1'b0) begin errors++; $display("FAIL reset_halt: got %0b expected 0", bus1.halt); end
        checks++; if (bus1.retire_count !== 32'd0) begin errors++; $display("FAIL reset_retire_count: got %0d expected 0", bus1.retire_count); end
        checks++; if (bus1.rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %0h expected 0", bus1.rd_data); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_pc_trigger();
        set_mode(2'b00, 64'h40, 1'b0);
        do_arm();
        checks++; if (bus1.state !== 2'b01) begin errors++; $display("FAIL pc_armed: got %0h expected 1", bus1.state); end
        for (int i = 0; i < 16; i++) straight(64'(i * 4));
        checks++; if (bus1.state !== 2'b01) begin errors++; $display("FAIL pc_pre_trig: got %0h expected 1", bus1.state); end
        straight(64'h40);
        checks++; if (bus1.state !== 2'b10) begin errors++; $display("FAIL pc_post: got %0h expected 2", bus1.state); end
        for (int i = 17; i < 24; i++) straight(64'(i * 4));
        checks++; if (bus1.state !== 2'b10) begin errors++; $display("FAIL pc_post_7: got %0h expected 2", bus1.state); end
        straight(64'h60);
        checks++; if (bus1.state !== 2'b11) begin errors++; $display("FAIL pc_done: got %0h expected 3", bus1.state); end
        checks++; if (bus1.entries !== 5'd16) begin errors++; $display("FAIL pc_entries: got %0d expected 16", bus1.entries); end
        checks++; if (bus1.trig_pos !== 4'd7) begin errors++; $display("FAIL pc_trig_pos: got %0d expected 7", bus1.trig_pos); end
        read1(4'd7, d);
        checks++; if (d !== ent_s(64'h40)) begin errors++; $display("FAIL pc_trig_entry: got %0h expected %0h", d, ent_s(64'h40)); end
        read1(4'd15, d);
        checks++; if (d !== ent_s(64'h60)) begin errors++; $display("FAIL pc_newest: got %0h expected %0h", d, ent_s(64'h60)); end
        read1(4'd0, d);
        checks++; if (d !== ent_s(64'h24)) begin errors++; $display("FAIL pc_oldest: got %0h expected %0h", d, ent_s(64'h24)); end
        checks++; if (bus1.retire_count !== 32'd25) begin errors++; $display("FAIL pc_retire_count: got %0d expected 25", bus1.retire_count); end
        straight(64'h64);
        read1(4'd15, d);
        checks++; if (d !== ent_s(64'h60)) begin errors++; $display("FAIL pc_frozen: got %0h expected %0h", d, ent_s(64'h60)); end
        checks++; if (bus1.retire_count !== 32'd26) begin errors++; $display("FAIL pc_count_in_done: got %0d expected 26", bus1.retire_count); end
    endtask

    task automatic test_wrap();
        set_mode(2'b00, 64'h54, 1'b0);
        do_arm();
        for (int i = 0; i < 30; i++) straight(64'(i * 4));
        checks++; if (bus1.state !== 2'b11) begin errors++; $display("FAIL wrap_done: got %0h expected 3", bus1.state); end
        checks++; if (bus1.entries !== 5'd16) begin errors++; $display("FAIL wrap_entries: got %0d expected 16", bus1.entries); end
        checks++; if (bus1.trig_pos !== 4'd7) begin errors++; $display("FAIL wrap_trig_pos: got %0d expected 7", bus1.trig_pos); end
        read1(4'd0, d);
        checks++; if (d !== ent_s(64'h38)) begin errors++; $display("FAIL wrap_oldest: got %0h expected %0h", d, ent_s(64'h38)); end
        read1(4'd7, d);
        checks++; if (d !== ent_s(64'h54)) begin errors++; $display("FAIL wrap_trig_entry: got %0h expected %0h", d, ent_s(64'h54)); end
        checks++; if (bus1.retire_count !== 32'd30) begin errors++; $display("FAIL wrap_retire_count: got %0d expected 30", bus1.retire_count); end
    endtask

    task automatic test_store_trigger();
        set_mode(2'b01, 64'h20, 1'b0);
        do_arm();
        retire(64'h0, 64'h4, NOP, 5'd5, 64'h20, 1'b1, 1'b0, 64'h20, 1'b0);
        retire(64'h4, 64'h8, SD, 5'd0, 64'h55, 1'b0, 1'b1, 64'h18, 1'b0);
        straight(64'h8);
        checks++; if (bus1.state !== 2'b01) begin errors++; $display("FAIL store_no_false_trig: got %0h expected 1", bus1.state); end
        retire(64'hc, 64'h10, SD, 5'd0, 64'h77, 1'b0, 1'b1, 64'h20, 1'b0);
        checks++; if (bus1.state !== 2'b10) begin errors++; $display("FAIL store_post: got %0h expected 2", bus1.state); end
        for (int i = 4; i < 12; i++) straight(64'(i * 4));
        checks++; if (bus1.state !== 2'b11) begin errors++; $display("FAIL store_done: got %0h expected 3", bus1.state); end
        checks++; if (bus1.entries !== 5'd12) begin errors++; $display("FAIL store_entries: got %0d expected 12", bus1.entries); end
        checks++; if (bus1.trig_pos !== 4'd3) begin errors++; $display("FAIL store_trig_pos: got %0d expected 3", bus1.trig_pos); end
        read1(4'd3, d);
        checks++; if (d !== ent(64'hc, SD, 5'd0, 64'h77, 1'b0, 1'b1)) begin errors++; $display("FAIL store_trig_entry: got %0h expected %0h", d, ent(64'hc, SD, 5'd0, 64'h77, 1'b0, 1'b1)); end
        read1(4'd12, d);
        checks++; if (d !== '0) begin errors++; $display("FAIL store_rd_beyond: got %0h expected 0", d); end
    endtask

    task automatic test_branch_trigger();
        set_mode(2'b10, 64'h0, 1'b1);
        do_arm();
        for (int i = 0; i < 4; i++) straight(64'(i * 4));
        checks++; if (bus1.state !== 2'b01) begin errors++; $display("FAIL branch_no_false_trig: got %0h expected 1", bus1.state); end
        retire(64'h10, 64'h40, BEQ, 5'd0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b1);
        checks++; if (bus1.state !== 2'b10) begin errors++; $display("FAIL branch_post: got %0h expected 2", bus1.state); end
        for (int i = 0; i < 8; i++) straight(64'h40 + 64'(i * 4));
        checks++; if (bus1.state !== 2'b11) begin errors++; $display("FAIL branch_done: got %0h expected 3", bus1.state); end
        checks++; if (bus1.trig_pos !== 4'd4) begin errors++; $display("FAIL branch_trig_pos: got %0d expected 4", bus1.trig_pos); end
        read1(4'd4, d);
        checks++; if (d !== ent(64'h10, BEQ, 5'd0, 64'd0, 1'b0, 1'b0)) begin errors++; $display("FAIL branch_trig_entry: got %0h expected %0h", d, ent(64'h10, BEQ, 5'd0, 64'd0, 1'b0, 1'b0)); end
        set_mode(2'b10, 64'h0, 1'b0);
    endtask

    task automatic test_idle_hold();
        set_mode(2'b11, 64'h0, 1'b0);
        do_arm();
        for (int i = 0; i < 3; i++) straight(64'(i * 4));
        drive(64'h0, 64'h0, NOP, 5'd0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
        bus1.trig_force = 1'b1; bus2.trig_force = 1'b1;
        repeat (4) tick();
        checks++; if (bus1.state !== 2'b01) begin errors++; $display("FAIL idle_state: got %0h expected 1", bus1.state); end
        checks++; if (bus1.entries !== 5'd3) begin errors++; $display("FAIL idle_entries: got %0d expected 3", bus1.entries); end
        checks++; if (bus1.retire_count !== 32'd3) begin errors++; $display("FAIL idle_retire_count: got %0d expected 3", bus1.retire_count); end
        straight(64'hc);
        checks++; if (bus1.state !== 2'b10) begin errors++; $display("FAIL manual_post: got %0h expected 2", bus1.state); end
        checks++; if (bus1.trig_pos !== 4'd3) begin errors++; $display("FAIL manual_trig_pos: got %0d expected 3", bus1.trig_pos); end
        set_mode(2'b11, 64'h0, 1'b0);
    endtask

    task automatic test_halt();
        set_mode(2'b00, 64'hdead, 1'b0);
        do_arm();
        straight(64'h78);
        straight(64'h7c);
        for (int i = 0; i < 15; i++) loop_retire();
        checks++; if (bus1.halt !== 1'b0) begin errors++; $display("FAIL halt_early: got %0b expected 0", bus1.halt); end
        loop_retire();
        checks++; if (bus1.halt !== 1'b1) begin errors++; $display("FAIL halt_rise: got %0b expected 1", bus1.halt); end
        checks++; if (bus1.state !== 2'b01) begin errors++; $display("FAIL halt_state: got %0h expected 1", bus1.state); end
        straight(64'h84);
        checks++; if (bus1.halt !== 1'b1) begin errors++; $display("FAIL halt_sticky: got %0b expected 1", bus1.halt); end
        do_arm();
        checks++; if (bus1.halt !== 1'b0) begin errors++; $display("FAIL halt_arm_clear: got %0b expected 0", bus1.halt); end
    endtask

    task automatic test_arm_priority();
        set_mode(2'b00, 64'h0, 1'b0);
        for (int i = 0; i < 9; i++) straight(64'(i * 4));
        checks++; if (bus1.state !== 2'b11) begin errors++; $display("FAIL prio_setup_done: got %0h expected 3", bus1.state); end
        drive(64'h0, 64'h4, NOP, 5'd0, 64'd0, 1'b1, 1'b0, 64'h100, 1'b0, 1'b1);
        bus1.arm = 1'b1; bus2.arm = 1'b1;
        tick();
        bus1.arm = 1'b0; bus2.arm = 1'b0;
        bus1.retire_valid = 1'b0; bus2.retire_valid = 1'b0;
        checks++; if (bus1.state !== 2'b01) begin errors++; $display("FAIL prio_state: got %0h expected 1", bus1.state); end
        checks++; if (bus1.entries !== 5'd0) begin errors++; $display("FAIL prio_entries: got %0d expected 0", bus1.entries); end
        checks++; if (bus1.retire_count !== 32'd0) begin errors++; $display("FAIL prio_retire_count: got %0d expected 0", bus1.retire_count); end
        straight(64'h0);
        checks++; if (bus1.state !== 2'b10) begin errors++; $display("FAIL prio_then_trig: got %0h expected 2", bus1.state); end
        checks++; if (bus1.entries !== 5'd1) begin errors++; $display("FAIL prio_then_entries: got %0d expected 1", bus1.entries); end
    endtask

    task automatic test_reset_mid();
        set_mode(2'b11, 64'h0, 1'b0);
        do_arm();
        for (int i = 0; i < 16; i++) loop_retire();
        bus1.trig_force = 1'b1; bus2.trig_force = 1'b1;
        loop_retire();
        bus1.trig_force = 1'b0; bus2.trig_force = 1'b0;
        checks++; if (bus1.state !== 2'b10 || bus1.halt !== 1'b1) begin errors++; $display("FAIL rstmid_setup: got state %0h halt %0b expected 2/1", bus1.state, bus1.halt); end
        #3 reset = 1'b1;
        #1;
        checks++; if (bus1.state !== 2'b00) begin errors++; $display("FAIL rstmid_state: got %0h expected 0", bus1.state); end
        checks++; if (bus1.halt !== 1'b0) begin errors++; $display("FAIL rstmid_halt: got %0b expected 0", bus1.halt); end
        checks++; if (bus1.retire_count !== 32'd0) begin errors++; $display("FAIL rstmid_retire_count: got %0d expected 0", bus1.retire_count); end
        checks++; if (bus1.entries !== 5'd0) begin errors++; $display("FAIL rstmid_entries: got %0d expected 0", bus1.entries); end
        #2 reset = 1'b0;
        tick();
    endtask

    task automatic test_post_trig0();
        set_mode(2'b00, 64'h8, 1'b0);
        do_arm();
        straight(64'h0);
        straight(64'h4);
        checks++; if (bus2.state !== 2'b01) begin errors++; $display("FAIL pt0_armed: got %0h expected 1", bus2.state); end
        straight(64'h8);
        checks++; if (bus2.state !== 2'b11) begin errors++; $display("FAIL pt0_done: got %0h expected 3", bus2.state); end
        checks++; if (bus2.entries !== 5'd3) begin errors++; $display("FAIL pt0_entries: got %0d expected 3", bus2.entries); end
        checks++; if (bus2.trig_pos !== 4'd2) begin errors++; $display("FAIL pt0_trig_pos: got %0d expected 2", bus2.trig_pos); end
        read2(4'd2, d);
        checks++; if (d !== ent_s(64'h8)) begin errors++; $display("FAIL pt0_newest: got %0h expected %0h", d, ent_s(64'h8)); end
        straight(64'hc);
        checks++; if (bus2.entries !== 5'd3) begin errors++; $display("FAIL pt0_frozen_entries: got %0d expected 3", bus2.entries); end
        checks++; if (bus2.retire_count !== 32'd4) begin errors++; $display("FAIL pt0_retire_count: got %0d expected 4", bus2.retire_count); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_pc_trigger();
        test_wrap();
        test_store_trigger();
        test_branch_trigger();
        test_idle_hold();
        test_halt();
        test_arm_priority();
        test_reset_mid();
        test_post_trig0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
